// File: rtl/fp_uscan.sv
// Front-panel microcode scanner: strobes uaddr and three ucontrol bytes off the
// fpd bus in turn and hands each completed frame over a one-deep valid/ready register.
module fp_uscan #(
  parameter int STROBE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        en,
  input  logic [7:0]  fpd,
  output logic        nfpua0,
  output logic        nfpuc0,
  output logic        nfpuc1,
  output logic        nfpuc2,
  output logic [7:0]  frame_uaddr,
  output logic [23:0] frame_uctl,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun,
  input  logic        clr_overrun,
  output logic        busy
);

  typedef enum logic [3:0] {IDLE, A0, BRK0, C0, BRK1, C1, BRK2, C2, GAP} state_t;

  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  ua_q, ua_d;
  logic [7:0]  c0_q, c0_d;
  logic [7:0]  c1_q, c1_d;
  logic [7:0]  frame_uaddr_q, frame_uaddr_d;
  logic [23:0] frame_uctl_q, frame_uctl_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        cnt_done;
  logic        complete;
  logic        drop;

  assign cnt_done = (cnt_q == 8'd0);
  assign complete = (state_q == C2) && cnt_done;
  assign drop     = complete && valid_q && !frame_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ua_q          <= '0;
      c0_q          <= '0;
      c1_q          <= '0;
      frame_uaddr_q <= '0;
      frame_uctl_q  <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ua_q          <= ua_d;
      c0_q          <= c0_d;
      c1_q          <= c1_d;
      frame_uaddr_q <= frame_uaddr_d;
      frame_uctl_q  <= frame_uctl_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ua_d          = ua_q;
    c0_d          = c0_q;
    c1_d          = c1_q;
    frame_uaddr_d = frame_uaddr_q;
    frame_uctl_d  = frame_uctl_q;
    valid_d       = valid_q;

    // Each strobe state captures fpd on the edge that ends its last cycle.
    case (state_q)
      IDLE: if (en) begin
        state_d = A0;
        cnt_d   = STROBE_LOAD;
      end
      A0: if (cnt_done) begin
        ua_d    = fpd;
        state_d = BRK0;
      end else cnt_d = cnt_q - 8'd1;
      BRK0: begin
        state_d = C0;
        cnt_d   = STROBE_LOAD;
      end
      C0: if (cnt_done) begin
        c0_d    = fpd;
        state_d = BRK1;
      end else cnt_d = cnt_q - 8'd1;
      BRK1: begin
        state_d = C1;
        cnt_d   = STROBE_LOAD;
      end
      C1: if (cnt_done) begin
        c1_d    = fpd;
        state_d = BRK2;
      end else cnt_d = cnt_q - 8'd1;
      BRK2: begin
        state_d = C2;
        cnt_d   = STROBE_LOAD;
      end
      C2: if (cnt_done) begin
        state_d = GAP;
        cnt_d   = GAP_LOAD;
      end else cnt_d = cnt_q - 8'd1;
      GAP: if (cnt_done) begin
        state_d = en ? A0 : IDLE;
        cnt_d   = en ? STROBE_LOAD : 8'd0;
      end else cnt_d = cnt_q - 8'd1;
      default: state_d = IDLE;
    endcase

    // A completing frame replaces the held one only if that one is gone or leaving now.
    if (complete && !drop) begin
      frame_uaddr_d = ua_q;
      frame_uctl_d  = {fpd, c1_q, c0_q};
      valid_d       = 1'b1;
    end else if (!complete && valid_q && frame_ready) begin
      valid_d = 1'b0;
    end

    overrun_d = drop | (overrun_q & ~clr_overrun);
  end

  always_comb begin
    nfpua0      = (state_q != A0);
    nfpuc0      = (state_q != C0);
    nfpuc1      = (state_q != C1);
    nfpuc2      = (state_q != C2);
    busy        = (state_q != IDLE);
    frame_uaddr = frame_uaddr_q;
    frame_uctl  = frame_uctl_q;
    frame_valid = valid_q;
    overrun     = overrun_q;
  end

endmodule

// File: tb/tb_fp_uscan.sv
// Bench for fp_uscan: a control-store model answers the strobes on fpd and a
// scoreboard checks every accepted frame against the values the model served.
module tb_fp_uscan;
  localparam int SC     = 4;
  localparam int GC     = 2;
  localparam int PERIOD = 4 * SC + 3 + GC;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        en = 1'b0;
  logic        frame_ready = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [7:0]  fpd;
  logic        nfpua0, nfpuc0, nfpuc1, nfpuc2;
  logic [7:0]  frame_uaddr;
  logic [23:0] frame_uctl;
  logic        frame_valid, overrun, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fall = -1;
  bit sb_on = 0, auto_inc = 0, meas_on = 0;
  logic [7:0]  cur_ua = 8'h00;
  logic [23:0] cur_uc = 24'h0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [7:0]  ua;
    logic [23:0] uc;
    logic [7:0]  exp_ua;
    logic [23:0] exp_uc;
  } vec_t;
  vec_t vecs[5];

  fp_uscan #(.STROBE_CYCLES(SC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .nreset(nreset), .en(en), .fpd(fpd),
    .nfpua0(nfpua0), .nfpuc0(nfpuc0), .nfpuc1(nfpuc1), .nfpuc2(nfpuc2),
    .frame_uaddr(frame_uaddr), .frame_uctl(frame_uctl),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .overrun(overrun), .clr_overrun(clr_overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Control-store side: answers whichever strobe is low, junk otherwise.
  always_comb begin
    if (!nfpua0)      fpd = cur_ua;
    else if (!nfpuc0) fpd = cur_uc[7:0];
    else if (!nfpuc1) fpd = cur_uc[15:8];
    else if (!nfpuc2) fpd = cur_uc[23:16];
    else              fpd = 8'hEE;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge nfpua0) begin
    if (auto_inc) cur_ua = cur_ua + 8'd1;
    if (meas_on && last_fall >= 0) check("a0_period", 32'(cyc - last_fall), 32'(PERIOD));
    last_fall = cyc;
    if (sb_on) sb_q.push_back({cur_ua, cur_uc});
  end

  always @(negedge clk) begin
    if (nreset) begin
      check("one_strobe_low", 32'(int'(!nfpua0) + int'(!nfpuc0) + int'(!nfpuc1) + int'(!nfpuc2) <= 1), 32'd1);
      if (sb_on && frame_valid && frame_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got frame %h expected none", {frame_uaddr, frame_uctl});
        end else begin
          logic [31:0] exp;
          exp = sb_q.pop_front();
          $display("frame accepted ua=%h uc=%h expected %h", frame_uaddr, frame_uctl, exp);
          check("sb_frame", {frame_uaddr, frame_uctl}, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_en();
    tick(); en = 1'b1;
    tick(); en = 1'b0;
  endtask

  task automatic wait_idle(int maxc);
    int n = 0;
    while (busy && n < maxc) begin tick(); n++; end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(int maxc);
    int n = 0;
    while (!frame_valid && n < maxc) begin tick(); n++; end
    check("valid_wait", 32'(frame_valid), 32'd1);
  endtask

  // Returns just after the edge that ends C2 (the completion edge).
  task automatic wait_c2_done(int maxc);
    int n = 0;
    while (nfpuc2 && n < maxc) begin tick(); n++; end
    while (!nfpuc2 && n < maxc) begin tick(); n++; end
    check("c2_wait", 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_c2_low(int maxc);
    int n = 0;
    while (nfpuc2 && n < maxc) begin tick(); n++; end
    check("c2_low_wait", 32'(nfpuc2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ua: 8'h5A, uc: 24'hC3A17E, exp_ua: 8'h5A, exp_uc: 24'hC3A17E};
    vecs[1] = '{ua: 8'h00, uc: 24'h000000, exp_ua: 8'h00, exp_uc: 24'h000000};
    vecs[2] = '{ua: 8'hFF, uc: 24'hFFFFFF, exp_ua: 8'hFF, exp_uc: 24'hFFFFFF};
    vecs[3] = '{ua: 8'hA5, uc: 24'h5A5A5A, exp_ua: 8'hA5, exp_uc: 24'h5A5A5A};
    vecs[4] = '{ua: 8'h01, uc: 24'h800001, exp_ua: 8'h01, exp_uc: 24'h800001};

    // Reset state
    #1 nreset = 1'b0;
    #1;
    check("rst_strobes", {nfpua0, nfpuc0, nfpuc1, nfpuc2}, 4'hF);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame", {frame_uaddr, frame_uctl}, 32'h0);
    repeat (2) @(posedge clk);
    #3 nreset = 1'b1;
    tick();

    // Table-driven single scans; first one also traces the strobe pattern
    sb_on = 1; frame_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      cur_ua = vecs[v].ua;
      cur_uc = vecs[v].uc;
      pulse_en();
      if (v == 0) begin
        for (int s = 0; s < 4; s++) begin
          for (int k = 0; k <= SC; k++) begin
            logic [3:0] exp_pat;
            if (k == SC && s == 3) break;
            exp_pat = (k == SC) ? 4'hF : (4'hF ^ (4'b1000 >> s));
            @(negedge clk);
            check("strobe_trace", {nfpua0, nfpuc0, nfpuc1, nfpuc2}, exp_pat);
          end
        end
        for (int k = 0; k < GC + 2; k++) begin
          @(negedge clk);
          check("gap_trace", {busy, nfpua0, nfpuc0, nfpuc1, nfpuc2}, (k < GC) ? 5'h1F : 5'h0F);
        end
        tick();
      end
      wait_idle(3 * PERIOD);
      tick();
      check("tbl_hold", {frame_uaddr, frame_uctl}, {vecs[v].exp_ua, vecs[v].exp_uc});
      check("tbl_valid_cleared", frame_valid, 1'b0);
    end
    check("tbl_sb_empty", 32'(sb_q.size()), 32'd0);

    // Continuous scanning with incrementing uaddr
    cur_ua = 8'h40; cur_uc = 24'h123456;
    auto_inc = 1; meas_on = 1; last_fall = -1;
    en = 1'b1;
    repeat (4 * PERIOD + 5) tick();
    en = 1'b0;
    wait_idle(3 * PERIOD);
    meas_on = 0; auto_inc = 0;
    check("cont_overrun", overrun, 1'b0);
    check("cont_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure
    sb_on = 0; frame_ready = 1'b0;
    cur_ua = 8'h10; cur_uc = 24'h222222; auto_inc = 1;
    en = 1'b1;
    wait_valid(2 * PERIOD);
    check("bp_first", {frame_uaddr, frame_uctl}, 32'h11222222);
    check("bp_no_overrun", overrun, 1'b0);
    wait_c2_done(2 * PERIOD);
    check("bp_overrun_set", overrun, 1'b1);
    check("bp_hold2", frame_uaddr, 8'h11);
    check("bp_valid", frame_valid, 1'b1);
    wait_c2_done(2 * PERIOD);
    check("bp_hold3", frame_uaddr, 8'h11);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("bp_clr", overrun, 1'b0);
    wait_c2_low(2 * PERIOD);
    repeat (SC - 1) tick();
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("bp_edge_align", nfpuc2, 1'b1);
    check("bp_set_wins", overrun, 1'b1);
    check("bp_hold4", frame_uaddr, 8'h11);
    auto_inc = 0;

    // Reset mid-scan while nfpuc1 is low
    begin
      int n = 0;
      while (nfpuc1 && n < 2 * PERIOD) begin tick(); n++; end
    end
    check("mid_c1_low", nfpuc1, 1'b0);
    check("mid_pre_overrun", overrun, 1'b1);
    #2 nreset = 1'b0;
    #1;
    check("mid_strobes", {nfpua0, nfpuc0, nfpuc1, nfpuc2}, 4'hF);
    check("mid_valid", frame_valid, 1'b0);
    check("mid_overrun", overrun, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_frame", {frame_uaddr, frame_uctl}, 32'h0);
    en = 1'b0;
    tick();
    #3 nreset = 1'b1;
    tick();

    // Accept and complete on the same edge
    cur_ua = 8'h77; cur_uc = 24'h777777;
    pulse_en();
    wait_valid(2 * PERIOD);
    check("same_first", {frame_uaddr, frame_uctl}, 32'h77777777);
    wait_idle(2 * PERIOD);
    cur_ua = 8'h88; cur_uc = 24'h888888;
    pulse_en();
    wait_c2_low(2 * PERIOD);
    repeat (SC - 1) tick();
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    check("same_valid", frame_valid, 1'b1);
    check("same_frame", {frame_uaddr, frame_uctl}, 32'h88888888);
    check("same_overrun", overrun, 1'b0);
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    check("same_drain", frame_valid, 1'b0);
    wait_idle(2 * PERIOD);

    // en dropped during C0: scan completes, then idle
    sb_on = 1; frame_ready = 1'b1;
    cur_ua = 8'h3C; cur_uc = 24'h0F1E2D;
    en = 1'b1;
    begin
      int n = 0;
      while (nfpuc0 && n < 2 * PERIOD) begin tick(); n++; end
    end
    check("drop_c0_low", nfpuc0, 1'b0);
    en = 1'b0;
    wait_c2_done(2 * PERIOD);
    begin
      int n = 0;
      while (busy && n < 20) begin tick(); n++; end
      check("drop_gap_len", 32'(n), 32'(GC));
    end
    begin
      bit saw_low = 0;
      repeat (2 * PERIOD) begin
        tick();
        if (!nfpua0 || busy) saw_low = 1;
      end
      check("drop_no_restart", 32'(saw_low), 32'd0);
    end
    check("drop_frame", {frame_uaddr, frame_uctl}, 32'h3C0F1E2D);
    check("drop_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
